// File: rtl/router_pkt_src.sv
// router_pkt_src: buffers one complete payload, then drives the router input
// with a header byte, the payload bytes and a trailing XOR parity byte,
// stalling on the router's busy. A fixed idle gap follows every packet.
module router_pkt_src #(
   parameter int GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  dest,
   input  logic [5:0]  len,
   output logic        req_ready,
   output logic        req_err,
   input  logic [7:0]  pl_data,
   input  logic        pl_valid,
   output logic        pl_ready,
   input  logic        busy,
   output logic        packet_valid,
   output logic [7:0]  pkt_data,
   output logic        done,
   output logic [15:0] pkt_count
);

   // Gap counter counts down the remaining gap cycles after the current one.
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY,
      ST_GAP
   } state_t;

   state_t          state_reg;
   logic [7:0]      header_reg;
   logic [5:0]      len_reg;
   logic [7:0]      parity_reg;
   logic [5:0]      wr_reg;
   logic [5:0]      rd_reg;
   logic [GW-1:0]   gap_reg;

   // Payload buffer; contents need no reset because every byte is written
   // before it is read within the same packet.
   logic [7:0]      mem [64];

   assign req_ready = (state_reg == ST_IDLE);
   assign pl_ready  = (state_reg == ST_LOAD);

   // Payload buffer write port, one byte per accepted beat in LOAD.
   always_ff @(posedge clk) begin
      if (pl_ready && pl_valid) begin
         mem[wr_reg] <= pl_data;
      end
   end

   // Packet sequencer: state, pointers, parity and all registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg    <= ST_IDLE;
         header_reg   <= 8'h00;
         len_reg      <= 6'd0;
         parity_reg   <= 8'h00;
         wr_reg       <= 6'd0;
         rd_reg       <= 6'd0;
         gap_reg      <= '0;
         packet_valid <= 1'b0;
         pkt_data     <= 8'h00;
         done         <= 1'b0;
         req_err      <= 1'b0;
         pkt_count    <= 16'd0;
      end else begin
         done    <= 1'b0;
         req_err <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if (dest == 2'd3 || len == 6'd0) begin
                     req_err <= 1'b1;
                  end else begin
                     header_reg <= {len, dest};
                     parity_reg <= {len, dest};
                     len_reg    <= len;
                     wr_reg     <= 6'd0;
                     state_reg  <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (pl_valid) begin
                  parity_reg <= parity_reg ^ pl_data;
                  wr_reg     <= wr_reg + 6'd1;
                  // Last payload byte: present the header on the next cycle.
                  if (wr_reg == len_reg - 6'd1) begin
                     state_reg    <= ST_HEADER;
                     packet_valid <= 1'b1;
                     pkt_data     <= header_reg;
                  end
               end
            end
            ST_HEADER: begin
               if (!busy) begin
                  rd_reg    <= 6'd0;
                  pkt_data  <= mem[6'd0];
                  state_reg <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (!busy) begin
                  rd_reg <= rd_reg + 6'd1;
                  if (rd_reg == len_reg - 6'd1) begin
                     // Parity travels with packet_valid low, as the router expects.
                     packet_valid <= 1'b0;
                     pkt_data     <= parity_reg;
                     state_reg    <= ST_PARITY;
                  end else begin
                     pkt_data <= mem[rd_reg + 6'd1];
                  end
               end
            end
            ST_PARITY: begin
               if (!busy) begin
                  pkt_data  <= 8'h00;
                  gap_reg   <= GAP_INIT;
                  state_reg <= ST_GAP;
                  // A single gap cycle is also the last one, so done fires now.
                  if (GAP_CYCLES == 1) begin
                     done      <= 1'b1;
                     pkt_count <= pkt_count + 16'd1;
                  end
               end
            end
            ST_GAP: begin
               if (gap_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  gap_reg <= gap_reg - 1'b1;
                  // done is high during the final gap cycle.
                  if (gap_reg == GW'(1)) begin
                     done      <= 1'b1;
                     pkt_count <= pkt_count + 16'd1;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: directed and randomized packets checked against a
// byte-stream model built from header/payload/parity rules.
module tb_router_pkt_src;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [1:0]  dest;
   logic [5:0]  len;
   logic        req_ready;
   logic        req_err;
   logic [7:0]  pl_data;
   logic        pl_valid;
   logic        pl_ready;
   logic        busy;
   logic        packet_valid;
   logic [7:0]  pkt_data;
   logic        done;
   logic [15:0] pkt_count;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_count = 16'd0;
   logic [7:0]  pay [64];
   int          stall [66];

   router_pkt_src #(.GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .dest         (dest),
      .len          (len),
      .req_ready    (req_ready),
      .req_err      (req_err),
      .pl_data      (pl_data),
      .pl_valid     (pl_valid),
      .pl_ready     (pl_ready),
      .busy         (busy),
      .packet_valid (packet_valid),
      .pkt_data     (pkt_data),
      .done         (done),
      .pkt_count    (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stall();
      for (int k = 0; k < 66; k++) stall[k] = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_pv"}, 16'(packet_valid), 16'd0);
      check({tag, "_data"}, 16'(pkt_data), 16'h00);
      check({tag, "_req_ready"}, 16'(req_ready), 16'd1);
      check({tag, "_pl_ready"}, 16'(pl_ready), 16'd0);
      check({tag, "_done"}, 16'(done), 16'd0);
      check({tag, "_count"}, pkt_count, exp_count);
   endtask

   // Expected stream: header {len,dest}, payload in order, XOR parity of all.
   // abort_at >= 0 applies reset while stream byte abort_at is presented.
   task automatic run_packet(input logic [1:0] d, input logic [5:0] l,
                             input bit rand_valid, input int abort_at);
      logic [7:0] exp_b [66];
      logic [7:0] par;
      int         i;
      int         guard;
      exp_b[0] = {l, d};
      par = exp_b[0];
      for (int j = 0; j < int'(l); j++) begin
         exp_b[j + 1] = pay[j];
         par = par ^ pay[j];
      end
      exp_b[int'(l) + 1] = par;

      check("req_ready_idle", 16'(req_ready), 16'd1);
      start = 1'b1; dest = d; len = l;
      tick();
      start = 1'b0;
      check("pl_ready_after_start", 16'(pl_ready), 16'd1);
      check("req_ready_in_load", 16'(req_ready), 16'd0);

      i = 0;
      guard = 0;
      while (i < int'(l)) begin
         check("pl_ready_load", 16'(pl_ready), 16'd1);
         check("pv_load", 16'(packet_valid), 16'd0);
         pl_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         pl_data  = pay[i];
         tick();
         if (pl_valid) i++;
         guard++;
         if (guard > 1000) begin
            check("load_timeout", 16'd0, 16'd1);
            break;
         end
      end
      pl_valid = 1'b0;
      pl_data  = 8'($urandom);

      for (int k = 0; k <= int'(l) + 1; k++) begin
         for (int h = 0; h <= stall[k]; h++) begin
            if (k == abort_at) begin
               resetn = 1'b0;
               busy   = 1'b0;
               tick();
               resetn = 1'b1;
               exp_count = 16'd0;
               check_idle_outputs("after_abort");
               tick();
               check("done_after_abort", 16'(done), 16'd0);
               $display("packet dest=%0d len=%0d aborted at byte %0d", d, l, k);
               return;
            end
            check("pkt_data", 16'(pkt_data), 16'(exp_b[k]));
            check("packet_valid", 16'(packet_valid), (k <= int'(l)) ? 16'd1 : 16'd0);
            check("done_in_send", 16'(done), 16'd0);
            busy = (h < stall[k]);
            tick();
         end
      end
      busy = 1'b0;

      for (int g = 1; g <= GAP; g++) begin
         check("gap_data", 16'(pkt_data), 16'h00);
         check("gap_pv", 16'(packet_valid), 16'd0);
         check("gap_done", 16'(done), (g == GAP) ? 16'd1 : 16'd0);
         tick();
      end
      exp_count = exp_count + 16'd1;
      check("pkt_count", pkt_count, exp_count);
      check("done_cleared", 16'(done), 16'd0);
      check("req_ready_after", 16'(req_ready), 16'd1);
      $display("packet dest=%0d len=%0d parity=%02h count=%0d", d, l, par, exp_count);
   endtask

   task automatic reject(input logic [1:0] d, input logic [5:0] l);
      check("rej_req_ready_before", 16'(req_ready), 16'd1);
      start = 1'b1; dest = d; len = l;
      tick();
      start = 1'b0;
      check("rej_req_err", 16'(req_err), 16'd1);
      check("rej_req_ready", 16'(req_ready), 16'd1);
      check("rej_pv", 16'(packet_valid), 16'd0);
      check("rej_pl_ready", 16'(pl_ready), 16'd0);
      tick();
      check("rej_req_err_pulse", 16'(req_err), 16'd0);
      check("rej_req_ready_after", 16'(req_ready), 16'd1);
      check("rej_pv_after", 16'(packet_valid), 16'd0);
      $display("reject dest=%0d len=%0d", d, l);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; start = 1'b0; dest = 2'd0; len = 6'd0;
      pl_data = 8'h00; pl_valid = 1'b0; busy = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
      check("reset_req_err", 16'(req_err), 16'd0);
      resetn = 1'b1;
      tick();
      check_idle_outputs("post_reset");

      // Basic packet, no stalls
      clear_stall();
      pay[0] = 8'hFF; pay[1] = 8'h00; pay[2] = 8'hFF;
      run_packet(2'd0, 6'd3, 1'b0, -1);

      // Stall: header held 4 cycles, byte 55 held 2 cycles
      clear_stall();
      pay[0] = 8'hAA; pay[1] = 8'h55;
      stall[0] = 3; stall[2] = 1;
      run_packet(2'd1, 6'd2, 1'b0, -1);

      // Rejected requests
      reject(2'd3, 6'd5);
      reject(2'd0, 6'd0);

      // Maximum length
      clear_stall();
      for (int j = 0; j < 63; j++) pay[j] = 8'(j);
      run_packet(2'd2, 6'd63, 1'b0, -1);

      // Reset mid-payload, then a normal packet
      clear_stall();
      for (int j = 0; j < 5; j++) pay[j] = 8'($urandom);
      run_packet(2'd1, 6'd5, 1'b0, 3);
      run_packet(2'd2, 6'd5, 1'b0, -1);

      // Randomized packets with random valid gaps, stalls and rejects
      for (int n = 0; n < 12; n++) begin
         logic [1:0] rd_dest;
         logic [5:0] rd_len;
         clear_stall();
         rd_dest = 2'($urandom_range(0, 2));
         rd_len  = 6'($urandom_range(1, 20));
         for (int j = 0; j < int'(rd_len); j++) pay[j] = 8'($urandom);
         for (int k = 0; k <= int'(rd_len) + 1; k++)
            stall[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_packet(rd_dest, rd_len, 1'b1, -1);
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0) reject(2'd3, 6'($urandom_range(0, 63)));
            else reject(2'($urandom_range(0, 2)), 6'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
